vector_madd_writeback_stage: RTL and testbench

//  Downstream stage of the registered vector multiply-add unit (fixed 2-cycle issue-to-vd latency).

---
 rtl/dragonfang_pkg.sv | 13 +
 rtl/dragonfang_sync_fifo.sv | 58 +++++
 rtl/vector_madd_writeback_stage.sv | 99 +++++++++
 tb/tb_vector_madd_writeback_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dragonfang_pkg.sv
// rtl/dragonfang_pkg.sv - shared widths, latency default and writeback entry type
package dragonfang_pkg;

  localparam int VREG_ADDR_W  = 5;
  localparam int VLEN         = 64;
  localparam int MADD_LATENCY = 2;

  typedef struct packed {
    logic [VREG_ADDR_W-1:0] vd;
    logic [VLEN-1:0]        data;
  } wb_entry_t;

endpackage

// File: rtl/dragonfang_sync_fifo.sv
// rtl/dragonfang_sync_fifo.sv - synchronous FIFO with registered head, wrapping pointers
module dragonfang_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_madd_writeback_stage.sv
// rtl/vector_madd_writeback_stage.sv - tracks MAU issues, queues {vd, data} for writeback under credit control
// Optional VMAU_WB_BYPASS_EN: results may skip the FIFO when it is empty and the register file is ready.
module vector_madd_writeback_stage
  import dragonfang_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = MADD_LATENCY
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_issue_valid,
  output logic                     o_issue_ready,
  input  logic [VREG_ADDR_W-1:0]   i_issue_vd,
  input  logic [VLEN-1:0]          i_mau_vd,
  output logic                     o_wb_valid,
  input  logic                     i_wb_ready,
  output logic [VREG_ADDR_W-1:0]   o_wb_vd,
  output logic [VLEN-1:0]          o_wb_data,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [LATENCY-1:0]     r_tag_valid;
  logic [VREG_ADDR_W-1:0] r_tag_vd [LATENCY];

  logic                   w_accept;
  logic                   w_last_valid;
  wb_entry_t              w_result;
  wb_entry_t              w_head;
  logic                   w_fifo_push;
  logic                   w_fifo_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [OCC_W-1:0]       w_fifo_count;
  logic [OCC_W-1:0]       w_inflight;

  assign w_accept     = i_issue_valid & o_issue_ready;
  assign w_last_valid = r_tag_valid[LATENCY-1];
  assign w_result     = '{vd: r_tag_vd[LATENCY-1], data: i_mau_vd};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tag_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_vd[i] <= '0;
      end
    end else begin
      r_tag_valid[0] <= w_accept;
      r_tag_vd[0]    <= i_issue_vd;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_vd[i]    <= r_tag_vd[i-1];
      end
    end
  end

  // Credits cover both ops still inside the MAU and results parked in the FIFO
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + OCC_W'(r_tag_valid[i]);
    end
  end

  assign o_occupancy   = w_inflight + w_fifo_count;
  assign o_issue_ready = (o_occupancy < OCC_W'(DEPTH));
  assign w_fifo_pop    = ~w_fifo_empty & i_wb_ready;

`ifdef VMAU_WB_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_fifo_empty & w_last_valid;
  assign w_fifo_push = w_last_valid & ~(w_bypass & i_wb_ready) & ~w_fifo_full;
  assign o_wb_valid  = ~w_fifo_empty | w_last_valid;
  assign o_wb_vd     = w_bypass ? w_result.vd   : w_head.vd;
  assign o_wb_data   = w_bypass ? w_result.data : w_head.data;
`else
  assign w_fifo_push = w_last_valid & ~w_fifo_full;
  assign o_wb_valid  = ~w_fifo_empty;
  assign o_wb_vd     = w_head.vd;
  assign o_wb_data   = w_head.data;
`endif

  dragonfang_sync_fifo #(
    .T     (wb_entry_t),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_fifo_push),
    .i_data  (w_result),
    .i_pop   (w_fifo_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_vector_madd_writeback_stage.sv
// tb/tb_vector_madd_writeback_stage.sv - randomized scoreboard bench for the MAU writeback stage
module tb_vector_madd_writeback_stage;
  import dragonfang_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = MADD_LATENCY;
`ifdef VMAU_WB_BYPASS_EN
  localparam int WB_DELAY = LAT;
`else
  localparam int WB_DELAY = LAT + 1;
`endif

  logic                   i_clock;
  logic                   i_reset;
  logic                   i_issue_valid;
  logic                   o_issue_ready;
  logic [VREG_ADDR_W-1:0] i_issue_vd;
  logic [VLEN-1:0]        i_mau_vd;
  logic                   o_wb_valid;
  logic                   i_wb_ready;
  logic [VREG_ADDR_W-1:0] o_wb_vd;
  logic [VLEN-1:0]        o_wb_data;
  logic [$clog2(DEPTH):0] o_occupancy;

  vector_madd_writeback_stage #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_issue_valid (i_issue_valid),
    .o_issue_ready (o_issue_ready),
    .i_issue_vd    (i_issue_vd),
    .i_mau_vd      (i_mau_vd),
    .o_wb_valid    (o_wb_valid),
    .i_wb_ready    (i_wb_ready),
    .o_wb_vd       (o_wb_vd),
    .o_wb_data     (o_wb_data),
    .o_occupancy   (o_occupancy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // An accepted op is due for writeback from cycle 'avail' on, strictly in issue order
  typedef struct {
    logic [VREG_ADDR_W-1:0] vd;
    logic [VLEN-1:0]        data;
    int                     avail;
  } exp_t;

  exp_t            sb[$];
  logic [VLEN-1:0] mau_sched [16];
  int              cyc     = 0;
  int              cur_occ = 0;
  int              checks  = 0;
  int              errors  = 0;
  bit              started = 0;
  bit              in_reset = 1;

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input bit v, input logic [VREG_ADDR_W-1:0] vd, input logic [VLEN-1:0] d,
                       input bit wbr, input bit rst);
    @(posedge i_clock);
    #1;
    cyc++;
    cur_occ       = sb.size();
    i_reset       = rst;
    i_issue_valid = v;
    i_issue_vd    = vd;
    i_wb_ready    = wbr;
    i_mau_vd      = mau_sched[cyc % 16];
    mau_sched[(cyc + LAT) % 16] = d;
    in_reset      = rst;
    started       = 1;
    if (rst) begin
      sb.delete();
      cur_occ = 0;
    end else if (v && cur_occ < DEPTH) begin
      sb.push_back('{vd: vd, data: d, avail: cyc + WB_DELAY});
    end
  endtask

  task automatic idle(input bit wbr);
    drive(1'b0, '0, rnd_data(), wbr, 1'b0);
  endtask

  always @(negedge i_clock) begin : monitor
    bit ev;
    if (started) begin
      ev = !in_reset && sb.size() > 0 && sb[0].avail <= cyc;
      check("occupancy", 64'(o_occupancy), 64'(cur_occ));
      check("issue_ready", 64'(o_issue_ready), 64'(cur_occ < DEPTH));
      check("wb_valid", 64'(o_wb_valid), 64'(ev));
      if (in_reset) begin
        check("reset_wb_vd", 64'(o_wb_vd), 64'd0);
        check("reset_wb_data", o_wb_data, 64'd0);
      end else if (ev) begin
        check("wb_vd", 64'(o_wb_vd), 64'(sb[0].vd));
        check("wb_data", o_wb_data, sb[0].data);
        if (i_wb_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    i_reset       = 1'b1;
    i_issue_valid = 1'b0;
    i_issue_vd    = '0;
    i_mau_vd      = '0;
    i_wb_ready    = 1'b0;
    for (int i = 0; i < 16; i++) mau_sched[i] = rnd_data();

    repeat (3) drive(1'b0, '0, rnd_data(), 1'b0, 1'b1);
    idle(1'b1);

    // single op
    drive(1'b1, 5'd5, {VLEN/8{8'hA5}}, 1'b1, 1'b0);
    repeat (6) idle(1'b1);

    // stall fill: fifth issue must be refused
    for (int i = 1; i <= 5; i++) drive(1'b1, 5'(i), rnd_data(), 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    repeat (8) idle(1'b1);

    // park DEPTH-1 results, then push and pop together
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b1, 5'(10 + i), rnd_data(), 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 5'(20 + i), rnd_data(), 1'b1, 1'b0);
    repeat (6) idle(1'b1);

    // pointer wrap with toggling wb_ready
    for (int i = 0; i < 10; i++) drive(1'b1, 5'($urandom), rnd_data(), (i % 2) == 0, 1'b0);
    for (int i = 0; i < 14; i++) idle((i % 2) == 0);

    // throughput
    for (int i = 0; i < 16; i++) drive(1'b1, 5'(i), rnd_data(), 1'b1, 1'b0);
    repeat (6) idle(1'b1);

    // reset with ops in flight
    for (int i = 0; i < 3; i++) drive(1'b1, 5'(7 + i), rnd_data(), 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, rnd_data(), 1'b1, 1'b1);
    repeat (6) idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      drive(($urandom % 4) != 0, 5'($urandom), rnd_data(), ($urandom % 3) != 0, 1'b0);

    for (int k = 0; k < 40 && sb.size() > 0; k++) idle(1'b1);
    @(negedge i_clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
